// File: rtl/ysyx_041461_mem_arbiter_pkg.sv
// ysyx_041461_mem_arbiter_pkg: state/owner encodings and bus widths shared by the memory arbiter files
package ysyx_041461_mem_arbiter_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int MASK_W = 8;
  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP} arb_state_e;
  typedef enum logic [1:0] {ARB_NONE, ARB_IF, ARB_MEM} arb_owner_e;
endpackage

// File: rtl/ysyx_041461_arb_starve_ctr.sv
// ysyx_041461_arb_starve_ctr: saturating count of MEM grants made while IF waits
//   clk/rst : clock, asynchronous active-high reset
//   inc     : MEM granted while IF was eligible
//   clr     : IF granted
//   full    : count reached LIMIT, IF must win the next contested grant
module ysyx_041461_arb_starve_ctr #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic full
);
  localparam int W = $clog2(LIMIT + 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign full  = cnt_q == W'(LIMIT);
  assign cnt_d = clr ? '0 : (inc && !full) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/ysyx_041461_mem_arbiter.sv
// ysyx_041461_mem_arbiter: single-outstanding arbiter of the shared memory bus between IF and MEM
//   if_*   : fetch requester (req/addr/kill in, resp_valid/rdata out)
//   mem_*  : load/store requester (req/we/addr/wdata/wmask in, resp_valid/rdata out)
//   bus_*  : downstream valid/ready request channel plus response-valid channel
//   arb_busy : a transaction is in progress
//   Define YSYX_041461_ARB_AGE_EN to let a starved IF win after STARVE_LIMIT MEM grants.
module ysyx_041461_mem_arbiter
  import ysyx_041461_mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_kill,
  output logic              if_resp_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [MASK_W-1:0] mem_wmask,
  output logic              mem_resp_valid,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [MASK_W-1:0] bus_wmask,
  input  logic              bus_resp_valid,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              arb_busy
);
  arb_state_e state_q, state_d;
  arb_owner_e owner_q, owner_d;
  logic kill_q, kill_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, if_rdata_q, if_rdata_d, mem_rdata_q, mem_rdata_d;
  logic [MASK_W-1:0] wmask_q, wmask_d;
  logic if_ok, age_win, grant_if, grant_mem, kill_now;
  assign if_ok     = if_req && !if_kill;
  assign grant_if  = state_q == ARB_IDLE && if_ok && (!mem_req || age_win);
  assign grant_mem = state_q == ARB_IDLE && mem_req && !grant_if;
  // a flush in the response cycle still counts, so merge it with the sticky flag
  assign kill_now  = owner_q == ARB_IF && (kill_q || if_kill);
`ifdef YSYX_041461_ARB_AGE_EN
  ysyx_041461_arb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk  (clk),
    .rst  (rst),
    .inc  (grant_mem && if_ok),
    .clr  (grant_if),
    .full (age_win)
  );
`else
  // strict MEM priority: IF never ages past MEM
  assign age_win = STARVE_LIMIT < 0;
`endif
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    kill_d      = 1'b0;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    case (state_q)
      ARB_IDLE: begin
        owner_d = grant_mem ? ARB_MEM : grant_if ? ARB_IF : ARB_NONE;
        if (grant_mem || grant_if) begin
          state_d = ARB_ISSUE;
          addr_d  = grant_mem ? mem_addr : if_addr;
          we_d    = grant_mem && mem_we;
          wdata_d = grant_mem ? mem_wdata : '0;
          wmask_d = (grant_mem && mem_we) ? mem_wmask : '0;
        end
      end
      ARB_ISSUE: begin
        kill_d  = kill_now;
        state_d = bus_req_ready ? ARB_WAIT : ARB_ISSUE;
      end
      ARB_WAIT: begin
        kill_d = kill_now && !bus_resp_valid;
        if (bus_resp_valid) begin
          state_d     = kill_now ? ARB_IDLE : ARB_RESP;
          owner_d     = kill_now ? ARB_NONE : owner_q;
          if_rdata_d  = (owner_q == ARB_IF && !kill_now) ? bus_rdata : if_rdata_q;
          mem_rdata_d = owner_q == ARB_MEM ? bus_rdata : mem_rdata_q;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        owner_d = ARB_NONE;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      owner_q     <= ARB_NONE;
      kill_q      <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      kill_q      <= kill_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end
  assign bus_req_valid  = state_q == ARB_ISSUE;
  assign bus_we         = we_q;
  assign bus_addr       = addr_q;
  assign bus_wdata      = wdata_q;
  assign bus_wmask      = wmask_q;
  assign if_resp_valid  = state_q == ARB_RESP && owner_q == ARB_IF;
  assign mem_resp_valid = state_q == ARB_RESP && owner_q == ARB_MEM;
  assign if_rdata       = if_rdata_q;
  assign mem_rdata      = mem_rdata_q;
  assign arb_busy       = state_q != ARB_IDLE;
endmodule

// File: tb/tb_ysyx_041461_mem_arbiter.sv
// tb_ysyx_041461_mem_arbiter: randomized requesters and bus slave against a transaction-level model
module tb_ysyx_041461_mem_arbiter;
  localparam int STARVE = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic if_req = 0, if_kill = 0, mem_req = 0, mem_we = 0, bus_req_ready = 0, bus_resp_valid = 0;
  logic [31:0] if_addr = 0, mem_addr = 0;
  logic [63:0] mem_wdata = 0, bus_rdata = 0;
  logic [7:0] mem_wmask = 0;
  logic if_resp_valid, mem_resp_valid, bus_req_valid, bus_we, arb_busy;
  logic [63:0] if_rdata, mem_rdata, bus_wdata;
  logic [31:0] bus_addr;
  logic [7:0] bus_wmask;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  ysyx_041461_mem_arbiter #(.STARVE_LIMIT(STARVE)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_resp_valid(if_resp_valid), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wmask(bus_wmask),
    .bus_resp_valid(bus_resp_valid), .bus_rdata(bus_rdata), .arb_busy(arb_busy)
  );
  typedef struct packed {
    bit act, acc, is_if, killed, we;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0] wmask;
  } tx_t;
  tx_t tx = '0;
  bit pulse_if = 0, pulse_mem = 0, if_pend = 0, mem_pend = 0;
  logic [63:0] resp_data = 0;
  int starve = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic reset_checks();
    check("rst_bus_req_valid", bus_req_valid, 0);
    check("rst_if_resp_valid", if_resp_valid, 0);
    check("rst_mem_resp_valid", mem_resp_valid, 0);
    check("rst_arb_busy", arb_busy, 0);
    check("rst_bus_we", bus_we, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_wdata", bus_wdata, 0);
    check("rst_bus_wmask", bus_wmask, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_mem_rdata", mem_rdata, 0);
  endtask
  // one clock: check outputs against the model, drive new inputs, advance the model
  task automatic cycle(input int p_if, input int p_mem, input int p_rdy, input int p_resp, input int p_kill);
    bit wif, gi, gm;
    @(negedge clk);
    check("bus_req_valid", bus_req_valid, tx.act && !tx.acc);
    if (tx.act && !tx.acc) begin
      check("bus_addr", bus_addr, tx.addr);
      check("bus_we", bus_we, tx.we);
      check("bus_wmask", bus_wmask, tx.wmask);
      if (tx.we) check("bus_wdata", bus_wdata, tx.wdata);
    end
    check("if_resp_valid", if_resp_valid, pulse_if);
    check("mem_resp_valid", mem_resp_valid, pulse_mem);
    if (pulse_if) check("if_rdata", if_rdata, resp_data);
    if (pulse_mem && !tx.we) check("mem_rdata", mem_rdata, resp_data);
    check("arb_busy", arb_busy, tx.act || pulse_if || pulse_mem);
    if (pulse_if) if_pend = 0;
    if (pulse_mem) mem_pend = 0;
    if (!if_pend && !pulse_if && $urandom_range(99) < p_if) begin
      if_pend = 1;
      if_addr = $urandom;
    end
    if (!mem_pend && !pulse_mem && $urandom_range(99) < p_mem) begin
      mem_pend  = 1;
      mem_we    = 1'($urandom_range(1));
      mem_addr  = $urandom;
      mem_wdata = {$urandom, $urandom};
      mem_wmask = 8'($urandom);
    end
    if (tx.act && tx.is_if) if_addr = $urandom;
    if (tx.act && !tx.is_if) begin
      mem_we    = 1'($urandom_range(1));
      mem_addr  = $urandom;
      mem_wdata = {$urandom, $urandom};
      mem_wmask = 8'($urandom);
    end
    if_kill        = $urandom_range(99) < p_kill;
    if_req         = if_pend;
    mem_req        = mem_pend;
    if (if_kill) if_pend = 0;
    bus_req_ready  = $urandom_range(99) < p_rdy;
    bus_resp_valid = $urandom_range(99) < p_resp;
    bus_rdata      = {$urandom, $urandom};
    wif = if_req && !if_kill;
    if (pulse_if || pulse_mem) begin
      pulse_if  = 0;
      pulse_mem = 0;
    end else if (!tx.act) begin
`ifdef YSYX_041461_ARB_AGE_EN
      gi = wif && (!mem_req || starve == STARVE);
`else
      gi = wif && !mem_req;
`endif
      gm = mem_req && !gi;
      if (gi || gm) begin
        tx.act    = 1;
        tx.acc    = 0;
        tx.killed = 0;
        tx.is_if  = gi;
        tx.addr   = gi ? if_addr : mem_addr;
        tx.we     = gm && mem_we;
        tx.wdata  = mem_wdata;
        tx.wmask  = tx.we ? mem_wmask : 8'h0;
        starve    = gi ? 0 : wif ? starve + 1 : starve;
      end
    end else begin
      if (tx.is_if && if_kill) tx.killed = 1;
      if (!tx.acc) tx.acc = bus_req_ready;
      else if (bus_resp_valid) begin
        tx.act    = 0;
        resp_data = bus_rdata;
        pulse_if  = tx.is_if && !tx.killed;
        pulse_mem = !tx.is_if;
      end
    end
  endtask
  initial begin
    int n;
    repeat (2) @(negedge clk);
    reset_checks();
    rst = 0;
    repeat (300) cycle(30, 0, 60, 40, 0);
    repeat (600) cycle(30, 100, 50, 40, 0);
    repeat (300) cycle(40, 30, 10, 30, 0);
    repeat (1500) cycle(25, 25, 25, 25, 8);
    n = 0;
    while (!(tx.act && tx.acc) && n < 200) begin
      cycle(60, 30, 50, 0, 0);
      n++;
    end
    check("reach_wait_bound", n < 200, 1);
    @(posedge clk);
    #2 rst = 1;
    #1 reset_checks();
    tx = '0;
    pulse_if = 0;
    pulse_mem = 0;
    if_pend = 0;
    mem_pend = 0;
    starve = 0;
    {if_req, mem_req, if_kill, bus_req_ready, bus_resp_valid} = '0;
    @(negedge clk);
    rst = 0;
    repeat (400) cycle(30, 30, 50, 40, 5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ysyx_041461_mem_arbiter.md
Name: ysyx_041461_mem_arbiter

Overview:
Arbitrates the single shared memory bus port between the instruction fetch requester (IF) and the load/store requester (MEM) of the 5-stage RV64 pipeline. Holds at most one outstanding transaction. Drives a valid/ready request channel plus a response-valid channel downstream, and returns one-cycle response pulses to the owning requester. Supports cancellation of in-flight fetches on pipeline flush/trap.

Parameters:
STARVE_LIMIT, 4, consecutive MEM grants allowed while IF waits before IF is forced to win (used only with the optional feature).

Ports:
clk  in  1  core clock
rst  in  1  reset, asynchronous, active-high
if_req  in  1  fetch request pending (level)
if_addr  in  32  fetch address
if_kill  in  1  flush: discard current/pending fetch
if_resp_valid  out  1  one-cycle fetch data pulse
if_rdata  out  64  fetch data
mem_req  in  1  load/store request pending (level)
mem_we  in  1  1 = store
mem_addr  in  32  load/store address
mem_wdata  in  64  store data
mem_wmask  in  8  store byte mask
mem_resp_valid  out  1  one-cycle load data / store done pulse
mem_rdata  out  64  load data
bus_req_valid  out  1  downstream request valid
bus_req_ready  in  1  downstream accepts request
bus_we  out  1  downstream write enable
bus_addr  out  32  downstream address
bus_wdata  out  64  downstream write data
bus_wmask  out  8  downstream byte mask (0 for reads)
bus_resp_valid  in  1  downstream response
bus_rdata  in  64  downstream read data
arb_busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst=1): state IDLE, owner NONE, kill flag 0, starve counter 0; all outputs 0.
- FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE: grant evaluated each cycle. mem_req=1 grants MEM; otherwise if_req=1 && if_kill=0 grants IF. On grant, latch owner, addr, we, wdata, and wmask (wmask and we forced 0 for IF) into registers, then go to ISSUE.
- ISSUE: bus_req_valid=1 with the latched fields. These stay stable until bus_req_ready=1, then go to WAIT. bus_req_valid is never withdrawn before ready.
- WAIT: on bus_resp_valid=1, latch bus_rdata. If owner=IF and the kill flag is set, go to IDLE with no pulse. Otherwise go to RESP.
- RESP: exactly one cycle; the owner's resp_valid=1 and rdata=latched data, then IDLE. rdata holds its value until the next response. mem_rdata is undefined-but-stable for stores.
- Requester rule: req must be low in the cycle its resp_valid is high. A req still high in the following IDLE cycle is a new request.
- Latency: req high in IDLE cycle N -> bus_req_valid at N+1. bus_resp_valid at cycle M -> resp_valid at M+1. Next grant is evaluated at M+2, so back-to-back bus requests are spaced at least 3 cycles apart.
- Kill: if_kill=1 while owner=IF in ISSUE or WAIT, including the cycle bus_resp_valid arrives, sets the kill flag. The transaction still completes on the bus and its data is dropped. The kill flag clears on return to IDLE. if_kill in RESP has no effect; IF discards the pulse itself. if_kill never affects a MEM transaction.
- Simultaneous if_req and mem_req: MEM wins (older instruction).
- bus_resp_valid outside WAIT: ignored.
- Inputs if_addr, mem_* are sampled only at grant and may change afterwards.

Optional Feature:
YSYX_041461_ARB_AGE_EN.
- Defined: starve counter, width clog2(STARVE_LIMIT+1). It increments on each MEM grant made while if_req=1 && if_kill=0, and clears on any IF grant. When counter==STARVE_LIMIT and if_req=1 && if_kill=0, IF wins over mem_req.
- Undefined: strict MEM priority, no counter logic.

Decomposition:
- Shared defines header: state encodings (ARB_IDLE/ISSUE/WAIT/RESP, 2 bits), owner encodings (ARB_NONE/IF/MEM), and bus width constants (ADDR 32, DATA 64, MASK 8).
- Optional sub-module ysyx_041461_arb_starve_ctr (saturating starve counter), instantiated only under YSYX_041461_ARB_AGE_EN.
- Otherwise a single module.

Test Plan:
- IF only: if_addr=0x80000000, ready immediate, bus_resp_valid 2 cycles later with rdata=0x00000013_00000297 -> bus_req_valid 1 cycle after req; if_resp_valid pulse 1 cycle after response with matching data; mem_resp_valid stays 0.
- Simultaneous if_req and mem_req (store, addr 0x80001000, wdata 0xDEADBEEF, wmask 0x0F) -> first bus request has we=1, wmask=0x0F; IF is served next, with bus_we=0 and wmask=0.
- Backpressure: bus_req_ready low for 5 cycles -> bus_req_valid and fields stable all 5 cycles; exactly one transaction issued.
- Kill: if_kill pulsed during WAIT -> no if_resp_valid; arb_busy drops 1 cycle after bus_resp_valid; a following mem_req is granted normally.
- Reset mid-WAIT: rst asserted asynchronously -> all outputs 0 immediately; after release, the first request issues normally.
- AGE_EN with STARVE_LIMIT=4: mem_req and if_req held continuously -> 4 MEM transactions, then 1 IF, then MEM resumes. Without the macro, IF is never granted while mem_req is held.
